// File: rtl/mem_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_master_pkg
// Shared types for the external-memory stage: the pipeline Signals bundle,
// memory access types, the bus master FSM state, the registered bus request
// and small helpers for access size and alignment.
// Optional feature macro (used by mem_bus_master): MEM_BUS_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package mem_bus_master_pkg;

    // Memory access type carried in Signals.memt.
    typedef enum logic [2:0] {
        LoadByte  = 3'd0,
        LoadHalf  = 3'd1,
        LoadWord  = 3'd2,
        ULoadByte = 3'd3,
        ULoadHalf = 3'd4,
        StoreByte = 3'd5,
        StoreHalf = 3'd6,
        StoreWord = 3'd7
    } MemType;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } MemSize;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } MemBusState;

    // Bit of Signals.wdata that flags a misaligned-access fault.
    localparam int MEM_FAULT_BIT = 32;

    // Pipeline bundle. wdata holds the address on the way in and the
    // writeback value (plus fault flag) on the way out.
    typedef struct packed {
        logic        valid;
        logic        memr;
        logic        memw;
        MemType      memt;
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [32:0] wdata;
        logic [31:0] reg2;
    } Signals;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } MemBusReq;

    function automatic MemSize mem_size(input MemType t);
        case (t)
            LoadByte, ULoadByte, StoreByte: return SZ_BYTE;
            LoadHalf, ULoadHalf, StoreHalf: return SZ_HALF;
            default:                        return SZ_WORD;
        endcase
    endfunction

    function automatic logic mem_misaligned(input MemSize sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: return a[0];
            SZ_WORD: return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for a 32-bit word bus.
//   i_memt   : access type (size and signedness)
//   i_addr   : low two address bits
//   i_reg2   : store data, LSB-aligned
//   i_rdata  : full load word from the bus
//   o_be     : byte enables for the access
//   o_wdata  : store data shifted into its lanes
//   o_rdata  : load data shifted down and sign/zero extended
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_bus_master_pkg::*;
(
    input  MemType      i_memt,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shift;
    logic [31:0] w_raw;

    always_comb begin
        o_be    = 4'b1111;
        w_shift = 5'd0;
        case (mem_size(i_memt))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                w_shift = {i_addr, 3'b000};
            end
            SZ_HALF: begin
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_shift = {i_addr[1], 4'b0000};
            end
            default: begin
                o_be    = 4'b1111;
                w_shift = 5'd0;
            end
        endcase
    end

    assign o_wdata = i_reg2 << w_shift;
    assign w_raw   = i_rdata >> w_shift;

    always_comb begin
        o_rdata = w_raw;
        case (i_memt)
            LoadByte:  o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
            ULoadByte: o_rdata = {24'h000000, w_raw[7:0]};
            LoadHalf:  o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
            ULoadHalf: o_rdata = {16'h0000, w_raw[15:0]};
            default:   o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
// Memory-stage initiator: turns load/store bundles into word requests on a
// valid/ready bus with byte enables, waits for load data, aligns/extends it
// and emits a registered writeback bundle. Non-memory bundles pass through
// with one cycle of latency.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_signals           : upstream bundle (wdata = address, reg2 = store data)
//   o_signals           : registered writeback bundle
//   stall               : combinational hold for the upstream pipeline
//   req_valid/req_ready : request handshake (req_valid registered)
//   req_we, req_addr, req_be, req_wdata : request fields, held until accepted
//   rsp_valid, rsp_rdata: load response (stores get none)
// Optional feature: define MEM_BUS_MISALIGN_TRAP_EN to complete misaligned
// half/word accesses immediately with the fault flag instead of issuing them.
// -----------------------------------------------------------------------------
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  Signals            i_signals,
    output Signals            o_signals,
    output logic              stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_be,
    output logic [31:0]       req_wdata,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_rdata
);

    MemBusState r_state, w_state_next;
    Signals     r_bundle, w_bundle_next;
    Signals     r_out, w_out_next;
    MemBusReq   r_req, w_req_next;
    logic       r_req_valid, w_req_valid_next;

    logic        w_memop;
    logic        w_misaligned;
    MemType      w_al_memt;
    logic [1:0]  w_al_addr;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    assign w_memop = i_signals.valid & (i_signals.memr ^ i_signals.memw);

`ifdef MEM_BUS_MISALIGN_TRAP_EN
    assign w_misaligned = mem_misaligned(mem_size(i_signals.memt), i_signals.wdata[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // In IDLE the aligner builds the request from the live input; once busy
    // it works from the latched bundle so load data is extended correctly.
    assign w_al_memt = (r_state == IDLE) ? i_signals.memt       : r_bundle.memt;
    assign w_al_addr = (r_state == IDLE) ? i_signals.wdata[1:0] : r_bundle.wdata[1:0];

    mem_lane_align u_align (
        .i_memt  (w_al_memt),
        .i_addr  (w_al_addr),
        .i_reg2  (i_signals.reg2),
        .i_rdata (rsp_rdata),
        .o_be    (w_be),
        .o_wdata (w_st_data),
        .o_rdata (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bundle    <= '0;
            r_out       <= '0;
            r_req       <= '0;
            r_req_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bundle    <= w_bundle_next;
            r_out       <= w_out_next;
            r_req       <= w_req_next;
            r_req_valid <= w_req_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_bundle_next    = r_bundle;
        w_req_next       = r_req;
        w_req_valid_next = r_req_valid;
        w_out_next       = '0;
        stall            = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_memop && w_misaligned) begin
                    // Fault completes in one cycle without touching the bus.
                    w_out_next                       = i_signals;
                    w_out_next.wdata                 = '0;
                    w_out_next.wdata[MEM_FAULT_BIT]  = 1'b1;
                end else if (w_memop) begin
                    w_bundle_next    = i_signals;
                    w_req_next.we    = i_signals.memw;
                    w_req_next.addr  = 32'({i_signals.wdata[ADDR_W-1:2], 2'b00});
                    w_req_next.be    = w_be;
                    w_req_next.wdata = w_st_data;
                    w_req_valid_next = 1'b1;
                    w_state_next     = REQ;
                    stall            = 1'b1;
                end else begin
                    w_out_next = i_signals;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (req_ready) begin
                    w_req_valid_next = 1'b0;
                    w_req_next       = '0;
                    if (r_req.we) begin
                        w_out_next       = r_bundle;
                        w_out_next.wdata = '0;
                        w_state_next     = IDLE;
                        stall            = 1'b0;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (rsp_valid) begin
                    w_out_next                      = r_bundle;
                    w_out_next.wdata[31:0]          = w_ld_data;
                    w_out_next.wdata[MEM_FAULT_BIT] = 1'b0;
                    w_state_next                    = IDLE;
                    stall                           = 1'b0;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_req_valid_next = 1'b0;
            end
        endcase

        // Upstream must never be held while the stage is being reset.
        if (rst) begin
            stall = 1'b0;
        end
    end

    assign o_signals = r_out;
    assign req_valid = r_req_valid;
    assign req_we    = r_req.we;
    assign req_addr  = r_req.addr[ADDR_W-1:0];
    assign req_be    = r_req.be;
    assign req_wdata = r_req.wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_master
// Drives directed and random bundles into mem_bus_master, plays the memory
// side with configurable ready/response delays and compares every output
// against expectations derived from size/lane arithmetic.
// Honors MEM_BUS_MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    Signals      i_signals;
    Signals      o_signals;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_signals (i_signals),
        .o_signals (o_signals),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int size_bytes(input MemType t);
        case (t)
            LoadByte, ULoadByte, StoreByte: return 1;
            LoadHalf, ULoadHalf, StoreHalf: return 2;
            default:                        return 4;
        endcase
    endfunction

    // Lowest byte lane touched: the address rounded down to the access size.
    function automatic int lane_of(input int nb, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return (lo / nb) * nb;
    endfunction

    function automatic logic [31:0] exp_load(input MemType t, input int nb,
                                             input int lane, input logic [31:0] w);
        longint full;
        longint v;
        full = longint'(1) << (8 * nb);
        v    = (longint'(w) >> (8 * lane)) & (full - 1);
        if ((t == LoadByte || t == LoadHalf) && v >= full / 2)
            v = v - full;
        return v[31:0];
    endfunction

    // ---------------- one full transaction ----------------
    task automatic run_txn(input Signals s, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] mem);
        logic [31:0] a;
        logic [31:0] wmask;
        logic [31:0] exp_st;
        logic [3:0]  be;
        int          nb;
        int          lane;
        bit          memop;
        bit          is_ld;
        bit          trap;
        Signals      exp_o;

        a     = s.wdata[31:0];
        memop = s.valid && (s.memr != s.memw);
        is_ld = memop && s.memr;
        nb    = size_bytes(s.memt);
        lane  = lane_of(nb, a);
        trap  = 1'b0;
`ifdef MEM_BUS_MISALIGN_TRAP_EN
        trap  = memop && ((int'(a[1:0]) % nb) != 0);
`endif
        be     = 4'(((1 << nb) - 1) << lane);
        for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
        exp_st = 32'(longint'(s.reg2) << (8 * lane));

        exp_o = s;
        if (trap)            exp_o.wdata = 33'h1_0000_0000;
        else if (is_ld)      exp_o.wdata = {1'b0, exp_load(s.memt, nb, lane, mem)};
        else if (memop)      exp_o.wdata = 33'h0;

        n_txn++;
        $display("txn %0d valid=%0d r=%0d w=%0d t=%0d addr=%h reg2=%h mem=%h rdy=%0d rsp=%0d",
                 n_txn, s.valid, s.memr, s.memw, s.memt, a, s.reg2, mem, rdy_dly, rsp_dly);

        i_signals = s;
        req_ready = 1'b0;
        rsp_valid = 1'($urandom);
        rsp_rdata = $urandom;
        #1;
        chk("stall_accept", stall, memop && !trap);

        if (!memop || trap) begin
            @(posedge clk); #1;
            chk("out_pass", o_signals, exp_o);
            chk("reqv_idle", req_valid, 1'b0);
            return;
        end

        for (int n = 0; n <= rdy_dly; n++) begin
            @(posedge clk); #1;
            chk("req_valid", req_valid, 1'b1);
            chk("req_we", req_we, !is_ld);
            chk("req_addr", req_addr, a & ~32'h3);
            chk("req_be", req_be, be);
            if (!is_ld) chk("req_wdata", req_wdata & wmask, exp_st & wmask);
            chk("busy_ovalid", o_signals.valid, 1'b0);
            req_ready = (n == rdy_dly);
            rsp_valid = 1'($urandom);
            rsp_rdata = $urandom;
            #1;
            chk("stall_req", stall, is_ld || (n != rdy_dly));
        end
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk("req_drop", req_valid, 1'b0);
        if (!is_ld) begin
            chk("out_store", o_signals, exp_o);
            return;
        end

        for (int m = 0; m <= rsp_dly; m++) begin
            if (m > 0) begin
                @(posedge clk); #1;
            end
            chk("busy_ovalid_w", o_signals.valid, 1'b0);
            chk("reqv_wait", req_valid, 1'b0);
            rsp_valid = (m == rsp_dly);
            rsp_rdata = (m == rsp_dly) ? mem : $urandom;
            #1;
            chk("stall_wait", stall, m != rsp_dly);
        end
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        chk("out_load", o_signals, exp_o);
    endtask

    // Reset while a load sits in WAIT, then a late response.
    task automatic reset_in_wait();
        Signals s;
        Signals b;
        s = '0;
        s.valid = 1'b1;
        s.memr  = 1'b1;
        s.memt  = LoadWord;
        s.rd    = 5'd7;
        s.wdata = 33'h0_0000_0040;
        b = '0;
        n_txn++;
        $display("txn %0d reset during WAIT, then late rsp_valid", n_txn);
        i_signals = s;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        @(posedge clk); #1;
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk("rw_reqv_drop", req_valid, 1'b0);
        @(posedge clk); #1;
        chk("rw_stall_wait", stall, 1'b1);
        rst = 1'b1;
        i_signals = b;
        #1;
        chk("rw_stall_rst", stall, 1'b0);
        @(posedge clk); #1;
        chk("rw_out_rst", o_signals, '0);
        chk("rw_reqv_rst", req_valid, 1'b0);
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rw_stall_late", stall, 1'b0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        chk("rw_out_late", o_signals, '0);
        chk("rw_reqv_late", req_valid, 1'b0);
    endtask

    function automatic Signals rand_sig();
        Signals s;
        int k;
        s       = '0;
        s.valid = 1'(($urandom % 8) != 0);
        k       = $urandom % 8;
        s.memr  = (k <= 2) || (k == 6);
        s.memw  = (k >= 3 && k <= 5) || (k == 6);
        if (s.memr && !s.memw) begin
            case ($urandom % 5)
                0:       s.memt = LoadByte;
                1:       s.memt = LoadHalf;
                2:       s.memt = LoadWord;
                3:       s.memt = ULoadByte;
                default: s.memt = ULoadHalf;
            endcase
        end else if (s.memw && !s.memr) begin
            case ($urandom % 3)
                0:       s.memt = StoreByte;
                1:       s.memt = StoreHalf;
                default: s.memt = StoreWord;
            endcase
        end else begin
            s.memt = MemType'(3'($urandom));
        end
        s.regw  = 1'($urandom);
        s.rd    = 5'($urandom);
        s.pc    = $urandom;
        s.wdata = {1'($urandom), $urandom};
        s.reg2  = $urandom;
        return s;
    endfunction

    function automatic Signals mk(input logic r, input logic w, input MemType t,
                                 input logic [31:0] a, input logic [31:0] d);
        Signals s;
        s       = '0;
        s.valid = 1'b1;
        s.memr  = r;
        s.memw  = w;
        s.memt  = t;
        s.regw  = r;
        s.rd    = 5'd5;
        s.pc    = 32'h0000_1000;
        s.wdata = {1'b0, a};
        s.reg2  = d;
        return s;
    endfunction

    initial begin
        Signals s;
        rst       = 1'b1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        i_signals = mk(1'b1, 1'b0, LoadWord, 32'h10, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out", o_signals, '0);
        chk("rst_reqv", req_valid, 1'b0);
        chk("rst_reqaddr", req_addr, 32'h0);
        chk("rst_reqbe", req_be, 4'h0);
        chk("rst_reqwe", req_we, 1'b0);
        chk("rst_reqwdata", req_wdata, 32'h0);
        chk("rst_stall", stall, 1'b0);
        i_signals = '0;
        rst = 1'b0;

        // Directed cases
        run_txn(mk(1'b1, 1'b0, LoadByte,  32'h0000_0103, 32'h0), 0, 0, 32'h80FF_1234);
        run_txn(mk(1'b0, 1'b1, StoreHalf, 32'h0000_0202, 32'h0000_ABCD), 3, 0, 32'h0);
        run_txn(mk(1'b1, 1'b0, ULoadHalf, 32'h0000_0002, 32'h0), 0, 5, 32'hF00D_0000);
        run_txn(mk(1'b0, 1'b0, LoadByte,  32'h1234_5678, 32'h0), 0, 0, 32'h0);
        run_txn(mk(1'b1, 1'b0, LoadWord,  32'h0000_0040, 32'h0), 0, 0, 32'hCAFE_F00D);
        run_txn(mk(1'b0, 1'b0, LoadByte,  32'h8765_4321, 32'h0), 0, 0, 32'h0);
        reset_in_wait();
        run_txn(mk(1'b0, 1'b0, StoreWord, 32'h0000_0099, 32'h0), 0, 0, 32'h0);
        run_txn(mk(1'b1, 1'b0, LoadWord,  32'h0000_0005, 32'h0), 1, 1, 32'h1357_9BDF);
        run_txn(mk(1'b1, 1'b1, LoadWord,  32'h0000_0010, 32'h0), 0, 0, 32'h0);
        run_txn(mk(1'b0, 1'b1, StoreByte, 32'h0000_0301, 32'h0000_00A5), 0, 0, 32'h0);
        run_txn(mk(1'b1, 1'b0, LoadHalf,  32'h0000_0003, 32'h0), 0, 0, 32'h8001_7FFF);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            s = rand_sig();
            run_txn(s, int'($urandom % 4), int'($urandom % 4), $urandom);
        end

        i_signals = '0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Memory-stage initiator that replaces the in-core RAM stage when data memory lives outside the core. Takes the pipeline's `Signals` bundle, converts loads and stores into word-oriented requests on a valid/ready bus with byte enables, and waits for the response. Performs lane alignment and sign/zero extension on load data. Holds the upstream pipeline with `stall` while a transaction is in flight, then emits a writeback `Signals` bundle.

## Interface
- `ADDR_W`, 32: bus address width. The address is `i_signals.wdata[ADDR_W-1:0]`.
- `clk` in 1: clock. The only clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_signals` in `Signals`: upstream bundle. Uses `valid`, `memr`, `memw`, `memt`, `wdata` (address), `reg2` (store data), plus pass-through fields.
- `o_signals` out `Signals`: registered writeback bundle.
- `stall` out 1: combinational. While it is high, upstream holds `i_signals` stable.
- `req_valid` out 1: request valid, registered.
- `req_ready` in 1: memory accepts the request.
- `req_we` out 1: 1 for a store, 0 for a load.
- `req_addr` out `ADDR_W`: word-aligned address, with bits [1:0] = 0.
- `req_be` out 4: byte enables.
- `req_wdata` out 32: store data, already shifted into its lanes.
- `rsp_valid` in 1: load data valid. Stores receive no response.
- `rsp_rdata` in 32: full load word.

## Operation
- A memory op is `i_signals.valid & (memr ^ memw)`. Every other input, including `valid=0` and `memr=memw=1`, is a pass-through. A pass-through registers all fields unchanged into `o_signals` after 1 cycle, with `stall=0`.
- Lane selection:
  - Byte access: `be = 1 << a[1:0]`, `shift = 8*a[1:0]`.
  - Half access: `be = a[1] ? 4'b1100 : 4'b0011`, `shift = 16*a[1]`.
  - Word access: `be = 4'b1111`, `shift = 0`.
- Store data: `req_wdata = reg2 << shift`. Bytes outside `be` are don't-care.
- Load data: `(rsp_rdata >> shift)`, truncated to 8 or 16 bits.
  - `LoadByte` and `LoadHalf` sign-extend to 32.
  - `ULoadByte` and `ULoadHalf` zero-extend.
  - `LoadWord` is the raw word.
  - `o_signals.wdata[32] = 0`.
- A completed store emits `wdata = 0`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on a memory op, latch the bundle, set `req_*`, and go to REQ. `stall=1`.
  - REQ: `req_valid=1`, request fields held constant. On `req_ready`:
    - Store: go to IDLE and emit the result. `stall=0` in this cycle.
    - Load: go to WAIT. `stall=1`.
  - WAIT: on `rsp_valid`, emit the load result and go to IDLE. `stall=0` in this cycle. Otherwise `stall=1`.
- While busy (REQ, or WAIT without a response), `o_signals.valid <= 0`. The other `o_signals` fields are don't-care.
- `rsp_valid` in IDLE or REQ is ignored.
- Reset:
  - State to IDLE, `req_valid=0`, `req_*` = 0, `o_signals` all zero, `stall=0` while `rst` is high.
  - Reset mid-transaction abandons the transaction with no output.
  - A late `rsp_valid` after reset is ignored.

## Timing
- Pass-through latency: 1 cycle.
- Store latency: 2 cycles minimum. Cycle 0 is accept. `req_valid` is high from cycle 1. The result is registered at the edge that ends the `req_ready` cycle.
- Load latency: 3 cycles minimum, with the response 1 cycle after acceptance. Each wait cycle adds 1.
- `req_valid` never drops before `req_ready`.
- At most one outstanding request.
- The next input is sampled in the cycle after completion.

## Configuration
- `MEM_BUS_MISALIGN_TRAP_EN`:
  - Defined: a misaligned op (half with `a[0]=1`, or word with `a[1:0]!=0`) issues no bus request. It completes from IDLE with 1-cycle latency: `wdata[31:0]=0`, `wdata[32]=1` (fault flag), `stall=0`.
  - Undefined: low address bits are silently ignored per the lane rules above. `wdata[32]` is always 0.

## Structure
- Add to the `Common` package:
  - the `MemBusState` enum `{IDLE, REQ, WAIT}`;
  - a `MemBusReq` struct `{we, addr, be, wdata}`;
  - the constant `MEM_FAULT_BIT = 32`.
- Sub-module `mem_lane_align` (combinational): takes `memt`, `addr[1:0]`, `reg2` and `rsp_rdata`; produces `be`, shifted store data and extended load data. Instantiated once.

## Test plan
- `LoadByte` at addr 0x103, memory word 0x80FF_1234, `req_ready` and response immediate:
  - `req_addr=0x100`, `be=1000`;
  - `o_signals.wdata=0xFFFF_FF80` at cycle 3.
- `StoreHalf` at 0x202, `reg2=0x0000_ABCD`, `req_ready` delayed 3 cycles:
  - `req_valid` held 4 cycles, `be=1100`, `req_wdata[31:16]=0xABCD`;
  - `stall` drops in the `req_ready` cycle.
- `ULoadHalf` at 0x002 with 5 wait cycles before `rsp_valid`, `rsp_rdata=0xF00D_0000`:
  - `o_signals.valid=0` for the duration;
  - then `wdata=0x0000_F00D`.
- Back-to-back: ALU op, then `LoadWord`, then ALU op:
  - ALU results appear 1 cycle after each is presented;
  - no dropped or duplicated `o_signals.valid`.
- `rst` asserted while in WAIT, then `rsp_valid` pulsed:
  - `o_signals` stays zero and the state is IDLE;
  - no output is produced.
- `LoadWord` at 0x005:
  - with `MEM_BUS_MISALIGN_TRAP_EN` defined: `req_valid` never rises, `wdata[32]=1`;
  - without it: `req_addr=0x004`, `be=1111`.
